// File: rtl/ws_pkg.sv
// Shared types and defaults for the weight-stationary array job sequencer.
// Holds the sequencer state encoding and the array op_sel codes.
package ws_pkg;

   localparam int DEF_IN_W    = 16;
   localparam int DEF_OUT_W   = 16;
   localparam int DEF_ROWS    = 1;
   localparam int DEF_COLS    = 4;
   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_RES_LAT = 5;

   localparam logic OP_PRELOAD = 1'b0;
   localparam logic OP_CONV    = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRELOAD,
      ST_STREAM,
      ST_DRAIN
   } ws_state_e;

endpackage

// File: rtl/ws_valid_pipe.sv
// Valid-tag delay line matching the array's fmap-to-result latency.
// tap marks the cycle the tagged result is on array_result; pend flags younger tags.
module ws_valid_pipe
   import ws_pkg::*;
#(
   parameter int RES_LAT = DEF_RES_LAT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic din,
   output logic tap,
   output logic pend
);

   logic [RES_LAT-1:0] v;

   generate
      if (RES_LAT == 1) begin : g_one
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               v <= '0;
            end else if (clr) begin
               v <= '0;
            end else begin
               v <= din;
            end
         end
         assign pend = 1'b0;
      end else begin : g_deep
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               v <= '0;
            end else if (clr) begin
               v <= '0;
            end else begin
               v <= {v[RES_LAT-2:0], din};
            end
         end
         assign pend = |v[RES_LAT-2:0];
      end
   endgenerate

   assign tap = v[RES_LAT-1];

endmodule

// File: rtl/ws_systolic_seq.sv
// Job sequencer: preloads weights, streams fmap vectors, drains and
// captures aligned partial sums from the weight-stationary array.
module ws_systolic_seq
   import ws_pkg::*;
#(
   parameter int IN_W    = DEF_IN_W,
   parameter int OUT_W   = DEF_OUT_W,
   parameter int ROWS    = DEF_ROWS,
   parameter int COLS    = DEF_COLS,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int RES_LAT = DEF_RES_LAT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [ADDR_W-1:0]      num_vec,
   output logic                   busy,
   output logic                   done,
   output logic                   w_rd_en,
   output logic [ADDR_W-1:0]      w_rd_addr,
   input  logic [ROWS*IN_W-1:0]   w_rd_data,
   output logic                   f_rd_en,
   output logic [ADDR_W-1:0]      f_rd_addr,
   input  logic [COLS*IN_W-1:0]   f_rd_data,
   output logic [ROWS*IN_W-1:0]   kernel_in,
   output logic [COLS*IN_W-1:0]   fmap_in,
   output logic                   op_sel,
   output logic [ROWS*OUT_W-1:0]  result_in,
   input  logic [ROWS*OUT_W-1:0]  array_result,
   output logic                   res_valid,
   output logic [ROWS*OUT_W-1:0]  res_data
);

   ws_state_e         state;
   logic [ADDR_W-1:0] nvec;
   logic              kvld;
   logic              fvld;
   logic              kill;
   logic              tap;
   logic              pend;

   assign kill = abort && (state != ST_IDLE);

   // Buffer read data is already registered; a one-cycle-late read tag gates it.
   assign kernel_in = kvld ? w_rd_data : '0;
   assign fmap_in   = fvld ? f_rd_data : '0;
   assign result_in = '0;

   ws_valid_pipe #(
      .RES_LAT (RES_LAT)
   ) u_vpipe (
      .clk  (clk),
      .rst  (rst),
      .clr  (kill),
      .din  (fvld),
      .tap  (tap),
      .pend (pend)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         nvec      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         w_rd_en   <= 1'b0;
         w_rd_addr <= '0;
         f_rd_en   <= 1'b0;
         f_rd_addr <= '0;
         kvld      <= 1'b0;
         fvld      <= 1'b0;
         op_sel    <= OP_PRELOAD;
      end else if (kill) begin
         state     <= ST_IDLE;
         nvec      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         w_rd_en   <= 1'b0;
         w_rd_addr <= '0;
         f_rd_en   <= 1'b0;
         f_rd_addr <= '0;
         kvld      <= 1'b0;
         fvld      <= 1'b0;
         op_sel    <= OP_PRELOAD;
      end else begin
         kvld <= w_rd_en;
         fvld <= f_rd_en;
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  state     <= ST_PRELOAD;
                  busy      <= 1'b1;
                  nvec      <= num_vec;
                  w_rd_en   <= 1'b1;
                  w_rd_addr <= ADDR_W'(COLS - 1);
               end
            end
            ST_PRELOAD: begin
               if (w_rd_addr == '0) begin
                  w_rd_en <= 1'b0;
                  if (nvec != '0) begin
                     state     <= ST_STREAM;
                     f_rd_en   <= 1'b1;
                     f_rd_addr <= '0;
                  end else begin
                     state <= ST_DRAIN;
                  end
               end else begin
                  w_rd_addr <= w_rd_addr - 1'b1;
               end
            end
            ST_STREAM: begin
               op_sel <= OP_CONV;
               if (f_rd_addr == nvec - 1'b1) begin
                  f_rd_en   <= 1'b0;
                  f_rd_addr <= '0;
                  state     <= ST_DRAIN;
               end else begin
                  f_rd_addr <= f_rd_addr + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (done) begin
                  state  <= ST_IDLE;
                  busy   <= 1'b0;
                  op_sel <= OP_PRELOAD;
               end else begin
                  op_sel <= OP_CONV;
                  // Last tag is at the tap (or none were issued): done lines up with it.
                  if (!fvld && !pend) begin
                     done <= 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_valid <= 1'b0;
         res_data  <= '0;
      end else if (kill) begin
         res_valid <= 1'b0;
         res_data  <= '0;
      end else begin
         res_valid <= tap;
         if (tap) begin
            res_data <= array_result;
         end
      end
   end

endmodule
